// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_target_pkg;

  localparam int BYTE_W = 8;

  // SDA bus levels for the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDRESS,
    ADDR_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    READ_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability counter for one I2C line.
// The filtered value only moves after FILTER_CYCLES consecutive differing samples.
module i2c_line_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1  <= 1'b1;
      sync_q2  <= 1'b1;
      count    <= 8'(FILTER_CYCLES - 1);
      filtered <= 1'b1;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == filtered) begin
        count <= 8'(FILTER_CYCLES - 1);
      end else if (count == 8'd0) begin
        filtered <= sync_q2;
        count    <= 8'(FILTER_CYCLES - 1);
      end else begin
        count <= count - 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: fixed 7-bit address, byte-stream user interface, no clock stretching.
// state      | meaning
// IDLE       | bus free or after STOP
// ADDRESS    | shifting in address + R/W
// ADDR_ACK   | driving ACK for our address
// WRITE_DATA | shifting in a write byte
// WRITE_ACK  | driving ACK/NACK for a write byte
// READ_DATA  | shifting out a read byte
// READ_ACK   | waiting for master ACK/NACK
// IGNORE     | not ours or read ended; wait for START/STOP
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h42,
  parameter int         FILTER_CYCLES  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_out_en,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_request,
  output logic              addressed,
  output logic              read_mode,
  output logic              stop_detected
);

  logic scl_f, sda_f, scl_prev, sda_prev;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  state_t            state, state_next;
  logic [2:0]        bit_cnt, bit_cnt_next;
  logic [BYTE_W-1:0] shift_q, shift_next;
  logic              byte_done, byte_done_next;
  logic              sda_out_en_next, addressed_next, read_mode_next;
  logic [BYTE_W-1:0] rx_data_next;
  logic              rx_valid_next, tx_request_next, stop_detected_next;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clock(clock), .reset_n(reset_n), .raw(scl_in), .filtered(scl_f)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clock(clock), .reset_n(reset_n), .raw(sda_in), .filtered(sda_f)
  );

  assign scl_rise   = scl_f & ~scl_prev;
  assign scl_fall   = ~scl_f & scl_prev;
  assign start_cond = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_cond  = scl_f & scl_prev & ~sda_prev & sda_f;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev      <= 1'b1;
      sda_prev      <= 1'b1;
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_q       <= '0;
      byte_done     <= 1'b0;
      sda_out_en    <= 1'b0;
      addressed     <= 1'b0;
      read_mode     <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      tx_request    <= 1'b0;
      stop_detected <= 1'b0;
    end else begin
      scl_prev      <= scl_f;
      sda_prev      <= sda_f;
      state         <= state_next;
      bit_cnt       <= bit_cnt_next;
      shift_q       <= shift_next;
      byte_done     <= byte_done_next;
      sda_out_en    <= sda_out_en_next;
      addressed     <= addressed_next;
      read_mode     <= read_mode_next;
      rx_data       <= rx_data_next;
      rx_valid      <= rx_valid_next;
      tx_request    <= tx_request_next;
      stop_detected <= stop_detected_next;
    end
  end

  always_comb begin
    state_next         = state;
    bit_cnt_next       = bit_cnt;
    shift_next         = shift_q;
    byte_done_next     = byte_done;
    sda_out_en_next    = sda_out_en;
    addressed_next     = addressed;
    read_mode_next     = read_mode;
    rx_data_next       = rx_data;
    rx_valid_next      = 1'b0;
    tx_request_next    = 1'b0;
    stop_detected_next = 1'b0;

    if (stop_cond) begin
      state_next         = IDLE;
      byte_done_next     = 1'b0;
      sda_out_en_next    = ~NACK;
      addressed_next     = 1'b0;
      read_mode_next     = 1'b0;
      stop_detected_next = 1'b1;
    end else if (start_cond) begin
      state_next      = ADDRESS;
      bit_cnt_next    = '0;
      byte_done_next  = 1'b0;
      sda_out_en_next = ~NACK;
      addressed_next  = 1'b0;
    end else begin
      unique case (state)
        ADDRESS, WRITE_DATA: begin
          if (scl_rise) begin
            shift_next   = {shift_q[BYTE_W-2:0], sda_f};
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_next = 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done_next = 1'b0;
            if (state == ADDRESS) begin
              if (shift_q[BYTE_W-1:1] == DEVICE_ADDRESS) begin
                sda_out_en_next = ~ACK;
                read_mode_next  = shift_q[0];
                state_next      = ADDR_ACK;
              end else begin
                state_next = IGNORE;
              end
            end else begin
              if (rx_ready) begin
                rx_data_next    = shift_q;
                rx_valid_next   = 1'b1;
                sda_out_en_next = ~ACK;
              end else begin
                sda_out_en_next = ~NACK;
              end
              state_next = WRITE_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            addressed_next  = 1'b1;
            tx_request_next = read_mode;
          end else if (scl_fall) begin
            bit_cnt_next = '0;
            if (read_mode) begin
              shift_next      = tx_data;
              sda_out_en_next = ~tx_data[BYTE_W-1];
              state_next      = READ_DATA;
            end else begin
              sda_out_en_next = ~NACK;
              state_next      = WRITE_DATA;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            sda_out_en_next = ~NACK;
            bit_cnt_next    = '0;
            state_next      = WRITE_DATA;
          end
        end
        READ_DATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_next = 1'b1;
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_next  = 1'b0;
              sda_out_en_next = ~NACK;
              state_next      = READ_ACK;
            end else begin
              shift_next      = {shift_q[BYTE_W-2:0], 1'b0};
              sda_out_en_next = ~shift_q[BYTE_W-2];
            end
          end
        end
        READ_ACK: begin
          // byte_done here marks "master acked, reload on next fall"
          if (scl_rise) begin
            if (sda_f == ACK) begin
              byte_done_next  = 1'b1;
              tx_request_next = 1'b1;
            end else begin
              state_next = IGNORE;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_next  = 1'b0;
            bit_cnt_next    = '0;
            shift_next      = tx_data;
            sda_out_en_next = ~tx_data[BYTE_W-1];
            state_next      = READ_DATA;
          end
        end
        IDLE, IGNORE: ;
        default: ;
      endcase
    end
  end

endmodule
